// File: rtl/branch_hazard_ctrl.sv
// Branch redirect / load-use hazard sequencer for the 5-stage core.
// Optional statistics counters are enabled by defining BR_STATS_EN.
module branch_hazard_ctrl #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic [6:0]      ex_op_code,
   input  logic            br_en,
   input  logic [XLEN-1:0] br_target,
   input  logic            ex_mem_read,
   input  logic [4:0]      ex_rd_addr,
   input  logic            id_valid,
   input  logic [4:0]      id_rs1_addr,
   input  logic [4:0]      id_rs2_addr,
   input  logic            fetch_ready,
   output logic            pc_sel,
   output logic [XLEN-1:0] pc_target,
   output logic            pc_stall,
   output logic            if_id_stall,
   output logic            if_id_flush,
   output logic            id_ex_flush,
   output logic            redirect_busy,
   output logic [31:0]     redirect_count,
   output logic [31:0]     stall_count
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
   localparam logic [1:0] ST_ACCEPT  = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;

   logic [1:0]      r_state;
   logic [3:0]      r_flush_cnt;
   logic [XLEN-1:0] r_target;

   logic [1:0]      w_state_nxt;
   logic [3:0]      w_flush_cnt_nxt;
   logic [XLEN-1:0] w_target_nxt;

   logic            w_take;
   logic            w_hz;
   logic            w_take_run;
   logic            w_hz_run;

   logic            w_pc_sel;
   logic [XLEN-1:0] w_pc_target;
   logic            w_pc_stall;
   logic            w_if_id_stall;
   logic            w_if_id_flush;
   logic            w_id_ex_flush;

   assign w_take = ex_valid & br_en & ((ex_op_code == OP_JAL) | (ex_op_code == OP_BRANCH));
   assign w_hz   = ex_valid & ex_mem_read & id_valid & (ex_rd_addr != 5'd0) &
                   ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));

   assign w_take_run = w_take & (r_state == ST_RUN);
   assign w_hz_run   = w_hz & ~w_take & (r_state == ST_RUN);

   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      w_target_nxt    = r_target;
      w_pc_sel        = 1'b0;
      w_pc_target     = '0;
      w_pc_stall      = 1'b0;
      w_if_id_stall   = 1'b0;
      w_if_id_flush   = 1'b0;
      w_id_ex_flush   = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_take) begin
               w_pc_sel      = 1'b1;
               w_pc_target   = br_target;
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
               w_target_nxt  = br_target;
               if (fetch_ready) begin
                  w_state_nxt     = ST_ACCEPT;
                  w_flush_cnt_nxt = FLUSH_INIT;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end else if (w_hz) begin
               w_pc_stall    = 1'b1;
               w_if_id_stall = 1'b1;
               w_id_ex_flush = 1'b1;
            end
         end
         ST_WAIT: begin
            w_pc_sel      = 1'b1;
            w_pc_target   = r_target;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            if (fetch_ready) begin
               w_state_nxt     = ST_ACCEPT;
               w_flush_cnt_nxt = FLUSH_INIT;
            end
         end
         ST_FLUSH: begin
            // Counter is loaded with FLUSH_CYCLES-1, so FLUSH lasts that many
            // cycles; the accept cycle itself supplies the first flush.
            w_if_id_flush   = 1'b1;
            w_flush_cnt_nxt = r_flush_cnt - 4'd1;
            if (r_flush_cnt <= 4'd1) begin
               w_state_nxt     = ST_RUN;
               w_flush_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= '0;
         r_target    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
         r_target    <= w_target_nxt;
      end
   end

   assign pc_sel        = w_pc_sel & ~rst;
   assign pc_target     = rst ? '0 : w_pc_target;
   assign pc_stall      = w_pc_stall & ~rst;
   assign if_id_stall   = w_if_id_stall & ~rst;
   assign if_id_flush   = w_if_id_flush & ~rst;
   assign id_ex_flush   = w_id_ex_flush & ~rst;
   assign redirect_busy = (r_state != ST_RUN) & ~rst;

`ifdef BR_STATS_EN
   logic [31:0] r_redirect_count;
   logic [31:0] r_stall_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_redirect_count <= '0;
         r_stall_count    <= '0;
      end else begin
         if (w_take_run) r_redirect_count <= r_redirect_count + 32'd1;
         if (w_hz_run)   r_stall_count    <= r_stall_count + 32'd1;
      end
   end

   assign redirect_count = rst ? '0 : r_redirect_count;
   assign stall_count    = rst ? '0 : r_stall_count;
`else
   logic w_stats_unused;
   assign w_stats_unused = w_take_run ^ w_hz_run;
   assign redirect_count = '0;
   assign stall_count    = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench: two instances (FLUSH_CYCLES=1 and 2) share stimulus.
module tb_branch_hazard_ctrl;

   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_ALU  = 7'b0110011;

   // {pc_sel, pc_stall, if_id_stall, if_id_flush, id_ex_flush, redirect_busy}
   localparam logic [5:0] F_IDLE = 6'b000000;
   localparam logic [5:0] F_RED  = 6'b100110;
   localparam logic [5:0] F_REDB = 6'b100111;
   localparam logic [5:0] F_FL   = 6'b000101;
   localparam logic [5:0] F_HZ   = 6'b011010;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [6:0]  ex_op_code;
   logic        br_en;
   logic [31:0] br_target;
   logic        ex_mem_read;
   logic [4:0]  ex_rd_addr;
   logic        id_valid;
   logic [4:0]  id_rs1_addr;
   logic [4:0]  id_rs2_addr;
   logic        fetch_ready;

   logic        a_pc_sel, a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_flush, a_busy;
   logic [31:0] a_pc_target, a_rc, a_sc;
   logic        b_pc_sel, b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_flush, b_busy;
   logic [31:0] b_pc_target, b_rc, b_sc;

   always #5 clk = ~clk;

   branch_hazard_ctrl #(.XLEN(32), .FLUSH_CYCLES(1)) u_dut_a (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op_code(ex_op_code), .br_en(br_en),
      .br_target(br_target), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
      .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .fetch_ready(fetch_ready), .pc_sel(a_pc_sel), .pc_target(a_pc_target),
      .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall), .if_id_flush(a_if_id_flush),
      .id_ex_flush(a_id_ex_flush), .redirect_busy(a_busy), .redirect_count(a_rc),
      .stall_count(a_sc)
   );

   branch_hazard_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) u_dut_b (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op_code(ex_op_code), .br_en(br_en),
      .br_target(br_target), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
      .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .fetch_ready(fetch_ready), .pc_sel(b_pc_sel), .pc_target(b_pc_target),
      .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall), .if_id_flush(b_if_id_flush),
      .id_ex_flush(b_id_ex_flush), .redirect_busy(b_busy), .redirect_count(b_rc),
      .stall_count(b_sc)
   );

   typedef struct {
      string       tag;
      logic [5:0]  fa;
      logic [31:0] ta;
      logic [5:0]  fb;
      logic [31:0] tb;
      logic [31:0] rc;
      logic [31:0] sc;
   } exp_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_rc = '0;
   logic [31:0] exp_sc = '0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk({e.tag, "/a_flags"}, 32'({a_pc_sel, a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_flush, a_busy}), 32'(e.fa));
         chk({e.tag, "/a_target"}, a_pc_target, e.ta);
         chk({e.tag, "/b_flags"}, 32'({b_pc_sel, b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_flush, b_busy}), 32'(e.fb));
         chk({e.tag, "/b_target"}, b_pc_target, e.tb);
         chk({e.tag, "/b_redirect_count"}, b_rc, e.rc);
         chk({e.tag, "/b_stall_count"}, b_sc, e.sc);
      end
   end

   task automatic push(input string tag, input logic [5:0] fa, input logic [31:0] ta,
                       input logic [5:0] fb, input logic [31:0] tb);
      exp_t e;
      e.tag = tag; e.fa = fa; e.ta = ta; e.fb = fb; e.tb = tb;
`ifdef BR_STATS_EN
      e.rc = exp_rc; e.sc = exp_sc;
`else
      e.rc = '0; e.sc = '0;
`endif
      q.push_back(e);
   endtask

   // Advance one cycle and return inputs to a quiet pattern.
   task automatic nxt();
      @(posedge clk);
      #1;
      rst = 1'b0; ex_valid = 1'b0; ex_op_code = OP_ALU; br_en = 1'b0;
      br_target = 32'h0000_0000; ex_mem_read = 1'b0; ex_rd_addr = 5'd0;
      id_valid = 1'b0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; fetch_ready = 1'b1;
   endtask

   task automatic set_hz(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = rd;
      id_valid = 1'b1; id_rs1_addr = rs1; id_rs2_addr = rs2;
   endtask

   initial begin
      rst = 1'b1;
      nxt();
      rst = 1'b1; ex_valid = 1'b1; br_en = 1'b1; ex_op_code = OP_JAL; br_target = 32'h0000_0F00;
      push("reset", F_IDLE, '0, F_IDLE, '0);
      nxt();
      push("idle", F_IDLE, '0, F_IDLE, '0);

      // beq taken with immediate fetch acceptance
      nxt();
      ex_valid = 1'b1; ex_op_code = OP_BR; br_en = 1'b1; br_target = 32'h0000_0100;
      push("beq", F_RED, 32'h100, F_RED, 32'h100);
      exp_rc++;
      nxt();
      push("beq+1", F_IDLE, '0, F_FL, '0);
      nxt();
      push("beq+2", F_IDLE, '0, F_IDLE, '0);

      // jal held in WAIT_ACK for 3 cycles; latched target must persist
      nxt();
      ex_valid = 1'b1; ex_op_code = OP_JAL; br_en = 1'b1; br_target = 32'h0000_2000; fetch_ready = 1'b0;
      push("jal_c1", F_RED, 32'h2000, F_RED, 32'h2000);
      exp_rc++;
      nxt();
      br_target = 32'hDEAD_BEEF; fetch_ready = 1'b0;
      push("jal_c2", F_REDB, 32'h2000, F_REDB, 32'h2000);
      nxt();
      set_hz(5'd5, 5'd1, 5'd5); ex_op_code = OP_BR; br_en = 1'b1; fetch_ready = 1'b0;
      push("jal_c3", F_REDB, 32'h2000, F_REDB, 32'h2000);
      nxt();
      push("jal_c4", F_REDB, 32'h2000, F_REDB, 32'h2000);
      nxt();
      push("jal_flush", F_IDLE, '0, F_FL, '0);
      nxt();
      push("jal_run", F_IDLE, '0, F_IDLE, '0);

      // load-use hazards; br_en on a non-branch opcode is ignored
      nxt();
      set_hz(5'd5, 5'd7, 5'd5); ex_op_code = OP_LOAD; br_en = 1'b1;
      push("hz_rs2", F_HZ, '0, F_HZ, '0);
      exp_sc++;
      nxt();
      push("hz_done", F_IDLE, '0, F_IDLE, '0);
      nxt();
      set_hz(5'd0, 5'd0, 5'd0);
      push("hz_rd0", F_IDLE, '0, F_IDLE, '0);
      nxt();
      set_hz(5'd9, 5'd9, 5'd3);
      push("hz_rs1", F_HZ, '0, F_HZ, '0);
      exp_sc++;
      nxt();
      set_hz(5'd9, 5'd9, 5'd3); id_valid = 1'b0;
      push("hz_idinv", F_IDLE, '0, F_IDLE, '0);
      nxt();
      ex_valid = 1'b1; ex_op_code = OP_ALU; br_en = 1'b1; br_target = 32'h0000_0700;
      push("alu_bren", F_IDLE, '0, F_IDLE, '0);
      nxt();
      ex_valid = 1'b0; ex_op_code = OP_JAL; br_en = 1'b1; br_target = 32'h0000_0700;
      push("jal_exinv", F_IDLE, '0, F_IDLE, '0);

      // taken bne together with a load-use hazard: take wins
      nxt();
      set_hz(5'd4, 5'd4, 5'd4); ex_op_code = OP_BR; br_en = 1'b1; br_target = 32'h0000_0300;
      push("bne_hz", F_RED, 32'h300, F_RED, 32'h300);
      exp_rc++;
      nxt();
      push("bne_hz+1", F_IDLE, '0, F_FL, '0);
      nxt();
      push("bne_hz+2", F_IDLE, '0, F_IDLE, '0);

      // reset while in WAIT_ACK aborts the redirect
      nxt();
      ex_valid = 1'b1; ex_op_code = OP_JAL; br_en = 1'b1; br_target = 32'h0000_4000; fetch_ready = 1'b0;
      push("rw_take", F_RED, 32'h4000, F_RED, 32'h4000);
      exp_rc++;
      nxt();
      fetch_ready = 1'b0;
      push("rw_wait", F_REDB, 32'h4000, F_REDB, 32'h4000);
      nxt();
      rst = 1'b1; fetch_ready = 1'b0;
      exp_rc = '0; exp_sc = '0;
      push("rw_rst", F_IDLE, '0, F_IDLE, '0);
      nxt();
      push("rw_rel1", F_IDLE, '0, F_IDLE, '0);
      nxt();
      push("rw_rel2", F_IDLE, '0, F_IDLE, '0);

      // counters restart from zero after reset
      nxt();
      ex_valid = 1'b1; ex_op_code = OP_BR; br_en = 1'b1; br_target = 32'h0000_0500;
      push("post_beq", F_RED, 32'h500, F_RED, 32'h500);
      exp_rc++;
      nxt();
      set_hz(5'd8, 5'd8, 5'd0);
      push("post_beq+1", F_HZ, '0, F_FL, '0);
      nxt();
      push("post_end", F_IDLE, '0, F_IDLE, '0);

      @(negedge clk);
      #1;
      chk("scoreboard_drain", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
